// File: rtl/vram_frame_reader.sv
// Frame fetch from DDR2 video RAM through MCB read port p1, streamed over valid/ready.
// Optional idle-cycle counter enabled by defining UNDERRUN_COUNT_EN.
module vram_frame_reader #(
   parameter int unsigned FRAME_WORDS = 38400,
   parameter int unsigned BURST_WORDS = 16,
   parameter int unsigned FIFO_DEPTH  = 64
) (
   input  logic        clk0,
   input  logic        reset,
   input  logic        calib_done,
   input  logic        start,
   input  logic [29:0] frame_base,
   output logic        p1_cmd_en,
   output logic [2:0]  p1_cmd_instr,
   output logic [5:0]  p1_cmd_bl,
   output logic [29:0] p1_cmd_byte_addr,
   input  logic        p1_cmd_full,
   output logic        p1_rd_en,
   input  logic [63:0] p1_rd_data,
   input  logic        p1_rd_empty,
   output logic [63:0] pix_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] underrun_count
);

   localparam int unsigned CW = $clog2(FRAME_WORDS + 1);
   localparam int unsigned OW = $clog2(FIFO_DEPTH + BURST_WORDS + 1);
   localparam logic [CW-1:0] LAST = CW'(FRAME_WORDS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [29:0]   base_q;
   logic [CW-1:0] issued_q, popped_q, delivered_q;
   logic [OW-1:0] outst_q;
   logic [31:0]   remaining, len;
   logic          credit_ok, issue, pop, accept, start_ok;

   always_comb begin
      remaining = 32'(FRAME_WORDS) - 32'(issued_q);
      len       = (remaining > 32'(BURST_WORDS)) ? 32'(BURST_WORDS) : remaining;
      credit_ok = (32'(outst_q) + len) <= 32'(FIFO_DEPTH);
   end

   assign busy     = (state_q != IDLE);
   assign start_ok = start && calib_done;
   assign accept   = pix_valid && pix_ready;
   assign issue    = (state_q == ISSUE) && !p1_cmd_full && (issued_q < LAST) && credit_ok;
   // Words with no outstanding credit are not ours; leave them in the MCB FIFO.
   assign pop      = busy && !p1_rd_empty && (!pix_valid || pix_ready)
                     && (outst_q != '0) && (popped_q < LAST);

   assign p1_cmd_en        = issue;
   assign p1_cmd_instr     = 3'b001;
   assign p1_cmd_bl        = issue ? 6'(len - 32'd1) : '0;
   assign p1_cmd_byte_addr = issue ? base_q + 30'({issued_q, 3'b000}) : '0;
   assign p1_rd_en         = pop;

   always_comb begin
      state_d    = state_q;
      frame_done = 1'b0;
      case (state_q)
         IDLE:  if (start_ok) state_d = ISSUE;
         ISSUE: if (issued_q == LAST) state_d = DRAIN;
         DRAIN: if (delivered_q == LAST) begin
                   frame_done = 1'b1;
                   state_d    = IDLE;
                end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk0) begin
      if (reset) begin
         state_q     <= IDLE;
         base_q      <= '0;
         issued_q    <= '0;
         popped_q    <= '0;
         delivered_q <= '0;
         outst_q     <= '0;
         pix_data    <= '0;
         pix_valid   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE) begin
            if (start_ok) begin
               base_q      <= frame_base & ~30'h7;
               issued_q    <= '0;
               popped_q    <= '0;
               delivered_q <= '0;
               outst_q     <= '0;
            end
         end else begin
            if (issue)  issued_q    <= issued_q + CW'(len);
            if (pop)    popped_q    <= popped_q + CW'(1);
            if (accept) delivered_q <= delivered_q + CW'(1);
            outst_q <= outst_q + (issue ? OW'(len) : '0) - (pop ? OW'(1) : '0);
         end
         if (pop) begin
            pix_data  <= p1_rd_data;
            pix_valid <= 1'b1;
         end else if (accept) begin
            pix_valid <= 1'b0;
         end
      end
   end

`ifdef UNDERRUN_COUNT_EN
   logic [15:0] underrun_q;

   // Only gaps strictly between the first and last delivered word count.
   always_ff @(posedge clk0) begin
      if (reset) begin
         underrun_q <= '0;
      end else if (state_q == IDLE && start_ok) begin
         underrun_q <= '0;
      end else if (busy && pix_ready && !pix_valid && (delivered_q != '0)
                   && (delivered_q != LAST) && (underrun_q != '1)) begin
         underrun_q <= underrun_q + 16'd1;
      end
   end

   assign underrun_count = underrun_q;
`else
   assign underrun_count = '0;
`endif

endmodule
